// File: rtl/showcase0_pkg.sv
// rtl/showcase0_pkg.sv - shared types, record layout and packing helper for the showcase0 result packer
package showcase0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Record layout: {sc_signal[47:40], cmp[39:34], 2'b00[33:32], c[31:0]}
    localparam int C_LSB    = 0;
    localparam int CMP_LSB  = 34;
    localparam int SC_LSB   = 40;
    localparam int RECORD_W = 48;

    function automatic logic [RECORD_W-1:0] pack_record(
        input logic [31:0] c,
        input logic [5:0]  cmp,
        input logic [7:0]  sc
    );
        logic [RECORD_W-1:0] rec;
        rec                 = '0;
        rec[C_LSB   +: 32]  = c;
        rec[CMP_LSB +: 6]   = cmp;
        rec[SC_LSB  +: 8]   = sc;
        return rec;
    endfunction

endpackage

// File: rtl/showcase0_result_fifo.sv
// rtl/showcase0_result_fifo.sv - DEPTH x W record FIFO with a registered head entry
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write request and data; taken when not full, or when full and popping
//   pop           remove head entry; ignored when empty
//   rdata         registered head entry, zero while empty
//   full, empty   occupancy flags derived from pointers with an extra wrap bit
//   count         current occupancy (0..DEPTH)
module showcase0_result_fifo
    import showcase0_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = RECORD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_next;
    logic [AW:0]   rd_ptr_next;
    logic [W-1:0]  head_q;
    logic [W-1:0]  head_next;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = head_q;

    assign wr_ptr_next = wr_ptr + (AW+1)'(push_ok);
    assign rd_ptr_next = rd_ptr + (AW+1)'(pop_ok);

    // The head register is loaded with whatever the head will be after this
    // edge. When the new head slot is the one being written right now, the
    // incoming data is forwarded because mem has not been updated yet.
    always_comb begin
        head_next = '0;
        if (wr_ptr_next != rd_ptr_next) begin
            if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0])) begin
                head_next = wdata;
            end else begin
                head_next = mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            head_q <= head_next;
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
            end
        end
    end

endmodule

// File: rtl/showcase0_result_packer.sv
// rtl/showcase0_result_packer.sv - captures showcase0 results into a FIFO of packed records with statistics
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   en                     capture enable
//   in_vld, c, cmp,        upstream sample strobe and fields
//   sc_signal
//   out_data, out_vld,     packed record stream {sc_signal, cmp, 2'b00, c}
//   out_rdy
//   busy                   FSM not in IDLE
//   eq_cnt                 saturating count of accepted samples with cmp[5]=1
//   drop_cnt               saturating count of samples lost to a full FIFO
module showcase0_result_packer
    import showcase0_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_vld,
    input  logic [31:0]         c,
    input  logic [5:0]          cmp,
    input  logic [7:0]          sc_signal,
    output logic [47:0]         out_data,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic                busy,
    output logic [CNT_W-1:0]    eq_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      ONE_ENTRY = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_next;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW:0]         fifo_count;
    logic [RECORD_W-1:0] fifo_rdata;
    logic                pop;
    logic                accept;
    logic                drop_evt;
    logic                will_empty;

    assign pop      = !fifo_empty && out_rdy;
    assign accept   = (state == ST_RUN) && in_vld && (!fifo_full || pop);
    assign drop_evt = (state == ST_RUN) && in_vld && fifo_full && !pop;

    // FIFO occupancy after this edge is zero; lets RUN/DRAIN leave for IDLE
    // on the same edge that removes the last record.
    assign will_empty = !accept && (fifo_empty || ((fifo_count == ONE_ENTRY) && pop));

    showcase0_result_fifo #(
        .DEPTH (DEPTH),
        .W     (RECORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (pack_record(c, cmp, sc_signal)),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_data = fifo_rdata;
    assign out_vld  = !fifo_empty;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_next = will_empty ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_next = ST_RUN;
                end else if (will_empty) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept && cmp[5] && (eq_cnt != {CNT_W{1'b1}})) begin
                eq_cnt <= eq_cnt + CNT_ONE;
            end
            if (drop_evt && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/showcase0_result_packer.md
SHOWCASE0_RESULT_PACKER -- requirements
Module: showcase0_result_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port en  in  1  capture enable from control.
REQ-006 SHALL have port in_vld  in  1  upstream sample strobe; c/cmp/sc_signal valid this cycle.
REQ-007 SHALL have port c  in  32  arithmetic result of showcase0.
REQ-008 SHALL have port cmp  in  6  comparator flags {cmp_5..cmp_0}.
REQ-009 SHALL have port sc_signal  in  8  case-decoder result.
REQ-010 SHALL have port out_data  out  48  packed record {sc_signal, cmp, 2'b00, c}.
REQ-011 SHALL have port out_vld  out  1  out_data holds a valid record.
REQ-012 SHALL have port out_rdy  in  1  downstream accepts record when out_vld & out_rdy.
REQ-013 SHALL have port busy  out  1  state != IDLE.
REQ-014 SHALL have port eq_cnt  out  CNT_W  count of accepted samples with cmp[5]=1.
REQ-015 SHALL have port drop_cnt  out  CNT_W  count of samples lost to a full FIFO.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN.
REQ-017 IDLE->RUN when en=1; RUN->DRAIN when en=0 and FIFO non-empty; RUN->IDLE when en=0 and FIFO empty; DRAIN->IDLE when FIFO becomes empty; DRAIN->RUN when en=1.
REQ-018 Sample accepted only in RUN with in_vld=1 and (FIFO not full or pop this cycle).
REQ-019 Samples with in_vld=1 in IDLE or DRAIN SHALL be ignored and not counted.
REQ-020 Full FIFO with simultaneous pop (out_vld & out_rdy) SHALL accept the push; occupancy unchanged.
REQ-021 In RUN, in_vld=1, FIFO full, no pop: sample discarded, drop_cnt +1.
REQ-022 Record accepted in cycle N SHALL appear on out_data with out_vld=1 from cycle N+1 when FIFO was empty (latency 1).
REQ-023 out_data SHALL be the oldest entry; strict FIFO order, no reordering or duplication.
REQ-024 out_data/out_vld SHALL stay stable while out_vld=1 and out_rdy=0.
REQ-025 Empty FIFO with simultaneous push: out_vld SHALL not assert combinationally from in_vld.
REQ-026 eq_cnt +1 per accepted sample with cmp[5]=1.
REQ-027 Both counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; full/empty via extra pointer bit.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, FIFO empty, out_vld=0, out_data=0, busy=0, eq_cnt=0, drop_cnt=0.
REQ-030 Reset mid-transfer SHALL discard all stored records; no record emitted after release until a new accept.
REQ-031 First state change after rst deassertion SHALL occur on a rising clk edge only.

Structure
REQ-032 Package showcase0_pkg SHALL hold state enum, record field offsets (C_LSB=0, CMP_LSB=34, SC_LSB=40) and RECORD_W=48.
REQ-033 Storage SHALL be sub-module showcase0_result_fifo (DEPTH x 48, registered head, push/pop/full/empty).
REQ-034 FSM, packing and counters SHALL reside in the top module.

Verification
REQ-035 en=1, one sample c=0x00000008, cmp=6'b100000, sc=0x03, out_rdy=1 -> out_data=0x03_80_00000008 next cycle, eq_cnt=1.
REQ-036 DEPTH=4, out_rdy=0, 6 consecutive samples -> 4 stored, drop_cnt=2, out_vld held with first record stable.
REQ-037 Full FIFO, out_rdy=1 and in_vld=1 same cycle -> no drop, order preserved across 8 records.
REQ-038 3 records queued, en->0 -> busy=1 in DRAIN, in_vld ignored, IDLE after 3rd pop, busy=0.
REQ-039 rst pulse while 2 records queued and out_rdy=0 -> out_vld=0 and counters 0 asynchronously, no stale record later.
REQ-040 CNT_W=4, 20 samples with cmp[5]=1 and continuous drain -> eq_cnt saturates at 15.
